// File: rtl/sec_to_hms.sv
// sec_to_hms -- converts a seconds-of-day count into binary hours, minutes
// and seconds using a restoring (shift-compare-subtract) division. The block
// performs one compare/subtract per clock, so a conversion takes a fixed
// number of cycles.
//
// Timing:
//   - Edge 0 samples start and captures sec_in.
//   - Edges 1-5 produce the hour bits; edges 6-11 produce the minute bits.
//   - Edge 12 publishes the results and pulses done.
//   - Edge 13 returns the block to IDLE.
//
// Ports:
//   cnt_clk  in   rising-edge clock
//   cnt_rst  in   asynchronous active-high reset
//   start    in   conversion request, sampled only while idle
//   sec_in   in   17-bit seconds-of-day to convert
//   busy     out  high from the start edge until the return to idle
//   done     out  one-cycle pulse when hours/minutes/seconds/err update
//   err      out  last captured sec_in exceeded MAX_SEC (results forced to 0)
//   hours    out  0-24
//   minutes  out  0-59
//   seconds  out  0-59
module sec_to_hms #(
  parameter logic [16:0] MAX_SEC = 17'h15180
) (
  input  logic        cnt_clk,
  input  logic        cnt_rst,
  input  logic        start,
  input  logic [16:0] sec_in,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [4:0]  hours,
  output logic [5:0]  minutes,
  output logic [5:0]  seconds
);

  localparam logic [16:0] SEC_PER_HOUR = 17'd3600;
  localparam logic [16:0] SEC_PER_MIN  = 17'd60;

  typedef enum logic [1:0] {IDLE, HOUR, MIN, DONE} state_t;

  state_t      state;
  logic [16:0] rem;
  logic [2:0]  idx;
  logic [4:0]  hr_acc;
  logic [5:0]  min_acc;
  logic        oor;
  // Set once the last minute bit is resolved. The cycle it spends high moves
  // the result publication to edge 12.
  logic        settle;

  logic [16:0] div_sh;
  logic        ge;
  logic [16:0] rem_sub;

  // Restoring step.
  //   - The divisor is shifted into place for the current bit index.
  //   - The shift is done at 17 bits, so 3600<<4 = 57600 fits without
  //     truncation.
  always_comb begin
    div_sh  = 17'd0;
    if (state == HOUR) begin
      div_sh = SEC_PER_HOUR << idx;
    end else begin
      div_sh = SEC_PER_MIN << idx;
    end
    ge      = (rem >= div_sh);
    rem_sub = rem - div_sh;
  end

  always_ff @(posedge cnt_clk or posedge cnt_rst) begin
    if (cnt_rst) begin
      state   <= IDLE;
      rem     <= 17'd0;
      idx     <= 3'd0;
      hr_acc  <= 5'd0;
      min_acc <= 6'd0;
      oor     <= 1'b0;
      settle  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      hours   <= 5'd0;
      minutes <= 6'd0;
      seconds <= 6'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rem     <= sec_in;
            oor     <= (sec_in > MAX_SEC);
            idx     <= 3'd4;
            hr_acc  <= 5'd0;
            min_acc <= 6'd0;
            settle  <= 1'b0;
            busy    <= 1'b1;
            state   <= HOUR;
          end
        end

        HOUR: begin
          if (ge) begin
            rem    <= rem_sub;
            hr_acc <= hr_acc | (5'd1 << idx);
          end
          if (idx == 3'd0) begin
            idx   <= 3'd5;
            state <= MIN;
          end else begin
            idx <= idx - 3'd1;
          end
        end

        MIN: begin
          if (!settle) begin
            if (ge) begin
              rem     <= rem_sub;
              min_acc <= min_acc | (6'd1 << idx);
            end
            if (idx == 3'd0) begin
              settle <= 1'b1;
            end else begin
              idx <= idx - 3'd1;
            end
          end else begin
            // The remainder is now below 60 and is the seconds field.
            // Out-of-range inputs still take the full latency, but publish
            // zeros with err set.
            settle <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
            if (oor) begin
              err     <= 1'b1;
              hours   <= 5'd0;
              minutes <= 6'd0;
              seconds <= 6'd0;
            end else begin
              err     <= 1'b0;
              hours   <= hr_acc;
              minutes <= min_acc;
              seconds <= rem[5:0];
            end
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sec_to_hms.sv
// Testbench for sec_to_hms.
//   - Directed cases cover the fixed latency, the range boundaries, the error
//     path, ignored restarts, a mid-conversion reset and isolation of sec_in
//     after capture.
//   - Randomized conversions are compared with a divide/modulo reference
//     model.
module tb_sec_to_hms;

  logic        cnt_clk = 1'b0;
  logic        cnt_rst;
  logic        start;
  logic [16:0] sec_in;
  logic        busy;
  logic        done;
  logic        err;
  logic [4:0]  hours;
  logic [5:0]  minutes;
  logic [5:0]  seconds;

  int n_vec = 0;
  int n_err = 0;

  always #5 cnt_clk = ~cnt_clk;

  sec_to_hms #(.MAX_SEC(17'h15180)) dut (
    .cnt_clk (cnt_clk),
    .cnt_rst (cnt_rst),
    .start   (start),
    .sec_in  (sec_in),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .hours   (hours),
    .minutes (minutes),
    .seconds (seconds)
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference: plain division on the seconds-of-day value.
  task automatic ref_hms(input int s, output int h, output int m,
                         output int sc, output int e);
    if (s > 86400) begin
      h = 0; m = 0; sc = 0; e = 1;
    end else begin
      h = s / 3600; m = (s % 3600) / 60; sc = s % 60; e = 0;
    end
  endtask

  // Runs one conversion started at edge 0.
  //   chg     >= 0 : sec_in is changed to this value just after edge 0.
  //   rs_edge >  0 : start is raised so that edge rs_edge samples it, with
  //                  sec_in = rs_val; the request must be ignored.
  task automatic run_conv(input string tag, input int s, input int chg,
                          input int rs_edge, input int rs_val);
    int h, m, sc, e;
    int done_edge, n_done, busy_hi;
    ref_hms(s, h, m, sc, e);
    done_edge = -1;
    n_done    = 0;
    busy_hi   = 0;
    @(negedge cnt_clk);
    start  = 1'b1;
    sec_in = 17'(s);
    @(posedge cnt_clk);
    #1;
    start = 1'b0;
    if (chg >= 0) sec_in = 17'(chg);
    for (int k = 1; k <= 16; k++) begin
      @(posedge cnt_clk);
      #1;
      if (done) begin
        n_done++;
        if (done_edge < 0) done_edge = k;
      end
      if (k <= 12 && busy) busy_hi++;
      if (k == 13) chk({tag, "_busy_low_13"}, int'(busy), 0);
      if (rs_edge > 0 && k == rs_edge - 1) begin
        start  = 1'b1;
        sec_in = 17'(rs_val);
      end
      if (rs_edge > 0 && k == rs_edge) start = 1'b0;
    end
    chk({tag, "_done_edge"}, done_edge, 12);
    chk({tag, "_done_count"}, n_done, 1);
    chk({tag, "_busy_1to12"}, busy_hi, 12);
    chk({tag, "_hours"}, int'(hours), h);
    chk({tag, "_minutes"}, int'(minutes), m);
    chk({tag, "_seconds"}, int'(seconds), sc);
    chk({tag, "_err"}, int'(err), e);
  endtask

  initial begin
    int n_done;
    int s, chg, rs_edge, rs_val, sel;
    cnt_rst = 1'b1;
    start   = 1'b0;
    sec_in  = 17'd0;
    repeat (3) @(posedge cnt_clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_hms", int'({hours, minutes, seconds}), 0);
    @(negedge cnt_clk);
    cnt_rst = 1'b0;

    // Directed cases.
    run_conv("d3661", 3661, -1, 0, 0);
    run_conv("d0", 0, -1, 0, 0);
    run_conv("d86399", 86399, -1, 0, 0);
    run_conv("d86400", 86400, -1, 0, 0);
    run_conv("d90000", 90000, -1, 0, 0);
    run_conv("d60", 60, -1, 0, 0);
    run_conv("restart", 3600, -1, 5, 7200);
    run_conv("secchg", 50000, 0, 0, 0);
    run_conv("d86399b", 86399, -1, 0, 0);

    // Reset at edge 7 of a conversion aborts it and clears the outputs.
    @(negedge cnt_clk);
    start  = 1'b1;
    sec_in = 17'd3661;
    @(posedge cnt_clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge cnt_clk);
    #1;
    cnt_rst = 1'b1;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_err", int'(err), 0);
    chk("mid_rst_hms", int'({hours, minutes, seconds}), 0);
    @(negedge cnt_clk);
    cnt_rst = 1'b0;
    n_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge cnt_clk);
      #1;
      if (done) n_done++;
    end
    chk("mid_rst_no_done", n_done, 0);
    chk("mid_rst_hold_hms", int'({hours, minutes, seconds}), 0);
    run_conv("after_rst", 45296, -1, 0, 0);

    // Randomized conversions. Ignored restarts can land anywhere from
    // mid-conversion to the DONE cycle, and sec_in is optionally disturbed
    // after capture.
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 6)       s = int'($urandom_range(0, 86400));
      else if (sel < 8)  s = int'($urandom_range(86401, 131071));
      else if (sel == 8) s = 86400 + int'($urandom_range(0, 1));
      else               s = int'($urandom_range(0, 59));
      chg     = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 131071)) : -1;
      rs_edge = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 13)) : 0;
      rs_val  = int'($urandom_range(0, 131071));
      run_conv($sformatf("rnd%0d", i), s, chg, rs_edge, rs_val);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
